// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus. Every grant is followed
// by TURN all-high-Z cycles so that two buffers are never enabled together.
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int TURN     = 1,
  localparam int OWNER_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  output logic [N-1:0]       gnt,
  output logic [OWNER_W-1:0] owner,
  output logic               busy,
  output logic               turn
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TURN_W = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [N-1:0]        gnt_n;
  logic [OWNER_W-1:0]  owner_n, ptr, ptr_n, pick, idx;
  logic                busy_n, turn_n, found;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [TURN_W-1:0]   tcnt, tcnt_n;

  // First requester at or after ptr, wrapping at N-1 (N need not be a power of 2).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end else begin
        found = found;
      end
      idx = (idx == OWNER_W'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    owner_n    = owner;
    busy_n     = busy;
    turn_n     = turn;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    tcnt_n     = tcnt;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n      = {{(N-1){1'b0}}, 1'b1} << pick;
          owner_n    = pick;
          busy_n     = 1'b1;
          hold_cnt_n = '0;
          state_n    = GRANT;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!req[owner] || hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          gnt_n   = '0;
          busy_n  = 1'b0;
          turn_n  = 1'b1;
          // A cut-off owner still requesting drops to lowest priority.
          ptr_n   = (owner == OWNER_W'(N - 1)) ? '0 : owner + 1'b1;
          tcnt_n  = '0;
          state_n = TURNAROUND;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      TURNAROUND: begin
        if (tcnt == TURN_W'(TURN - 1)) begin
          turn_n = 1'b0;
          if (found) begin
            gnt_n      = {{(N-1){1'b0}}, 1'b1} << pick;
            owner_n    = pick;
            busy_n     = 1'b1;
            hold_cnt_n = '0;
            state_n    = GRANT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: begin
        gnt_n   = '0;
        busy_n  = 1'b0;
        turn_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant with no turnaround.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      turn     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      busy     <= busy_n;
      turn     <= turn_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_cnt_n;
      tcnt     <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs per edge;
// a negedge monitor pops, compares and checks the bus invariants.
module tb_tristate_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int TURN     = 1;
  localparam int BOUND    = 4 * (MAX_HOLD + TURN);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy, turn;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] gnt;
    int           owner;
    logic         busy;
    logic         turn;
    logic         rst;
    logic [N-1:0] req;
  } exp_t;

  exp_t sb[$];

  // Reference model state: current owner (-1 when none), cycles held, gap left.
  int m_owner = -1, m_last = 0, m_held = 0, m_gap = 0, m_ptr = 0;

  tristate_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .TURN(TURN)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .owner(owner), .busy(busy), .turn(turn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_arbitrate();
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (m_owner < 0 && req[j]) begin
        m_owner = j;
        m_last  = j;
        m_held  = 1;
      end
    end
  endfunction

  // Advance the model by one edge using the current inputs and queue the result.
  function automatic void model_edge();
    exp_t e;
    if (reset) begin
      m_owner = -1; m_last = 0; m_held = 0; m_gap = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = TURN;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) model_arbitrate();
    end else begin
      model_arbitrate();
    end
    e.gnt   = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.owner = m_last;
    e.busy  = (m_owner >= 0);
    e.turn  = (m_gap > 0);
    e.rst   = reset;
    e.req   = req;
    sb.push_back(e);
  endfunction

  task automatic step(input logic [N-1:0] r, input logic rs);
    req   = r;
    reset = rs;
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_gnt(input string name, input logic [N-1:0] g);
    check(name, gnt, g);
  endtask

  // Monitor: compare against the scoreboard and check invariants every cycle.
  logic [N-1:0] last_nz = '0;
  int zeros = 0;
  int waits [N];
  initial foreach (waits[k]) waits[k] = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("gnt", gnt, e.gnt);
      check("busy", busy, e.busy);
      check("turn", turn, e.turn);
      if (e.busy || e.rst) check("owner", owner, e.owner);
      check("onehot0", $onehot0(gnt), 1);
      check("busy_eq_or_gnt", busy == |gnt, 1);
      check("turn_busy_excl", turn && busy, 0);
      check("gnt_implies_req", gnt & ~e.req, 0);
      if (e.rst) begin
        last_nz = '0;
        zeros = 0;
        foreach (waits[k]) waits[k] = 0;
      end else begin
        if (gnt != '0) begin
          if (last_nz != '0 && gnt != last_nz) check("turn_gap", zeros >= TURN, 1);
          last_nz = gnt;
          zeros = 0;
        end else begin
          zeros++;
        end
        for (int k = 0; k < N; k++) begin
          if (e.req[k] && !gnt[k]) waits[k]++;
          else waits[k] = 0;
          check("starvation", waits[k] <= BOUND, 1);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    // 1: reset dominance
    step(4'b1111, 1'b1);
    expect_gnt("rst_gnt0", 4'b0000);
    check("rst_busy0", busy, 0);
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    expect_gnt("rst_release", 4'b0001);
    check("rst_release_owner", owner, 0);
    // 2: short single request
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
    // 3: saturation rotation
    step(4'b0000, 1'b1);
    for (int i = 0; i < 24; i++) step(4'b1111, 1'b0);
    // 4: pointer fairness
    step(4'b0000, 1'b1);
    step(4'b0101, 1'b0);
    expect_gnt("fair_first", 4'b0001);
    step(4'b0100, 1'b0);
    step(4'b0101, 1'b0);
    expect_gnt("fair_next", 4'b0100);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    // 5: reset mid-grant
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b0);
    expect_gnt("mid_grant", 4'b1000);
    step(4'b1000, 1'b1);
    expect_gnt("mid_reset_gnt", 4'b0000);
    check("mid_reset_turn", turn, 0);
    step(4'b1001, 1'b0);
    expect_gnt("mid_after", 4'b0001);
    // 6: random stress with sticky requests
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(7) == 0) r[k] = ~r[k];
      step(r, 1'b0);
    end
    step(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
Name:
tristate_bus_arbiter

Overview:
- Round-robin arbiter that shares one tristate bus between N drivers.
- Each driver sits behind a tristate_buffer_ibt-style cell.
- gnt[k] drives the sel input of driver k's buffer, so at most one buffer is enabled at any time.
- A programmable turnaround gap, with all buffers high-Z, is inserted between bus owners so that drivers never contend.

Parameters:
- N, 4, number of requesters/drivers; legal range 2..16.
- MAX_HOLD, 4, maximum consecutive cycles one owner may hold the bus; must be ≥1.
- TURN, 1, idle (all-high-Z) cycles inserted after every grant ends; must be ≥1.
- OWNER_W (localparam), $clog2(N), width of the owner index.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous active-high reset.
- req, input, N, request per driver; level-sensitive, held high while the driver wants the bus.
- gnt, output, N, one-hot-or-zero grant; connects to the buffer sel inputs.
- owner, output, OWNER_W, index of the current owner; valid only while busy=1.
- busy, output, 1, high exactly when gnt != 0.
- turn, output, 1, high during turnaround cycles.

Behaviour:
- Interface: one clock, clk. Reset, reset, is synchronous and active-high. All outputs are registered.
- Reset values: gnt=0, owner=0, busy=0, turn=0. The round-robin pointer ptr=0 (requester 0 has highest priority). State is IDLE.
- Reset asserted mid-operation (any state) takes effect at the next edge: all outputs return to their reset values and any in-flight grant is dropped with no turnaround.
- State IDLE:
  - If req != 0 at an edge, select k = the first index with req[k]=1, searching ptr, ptr+1, ... wrapping mod N.
  - At that edge: gnt=1<<k, owner=k, busy=1, hold_cnt=0, go to GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req=0, remain in IDLE.
- State GRANT:
  - At each edge, if req[owner]=0 or hold_cnt==MAX_HOLD-1: gnt=0, busy=0, turn=1, ptr=(owner+1) mod N, tcnt=0, go to TURNAROUND.
  - Otherwise hold_cnt increments and gnt is held.
  - The gnt pulse length equals the number of cycles req[owner] was sampled high, capped at MAX_HOLD.
  - Requests from other drivers never preempt the owner; only release or MAX_HOLD ends a grant.
- State TURNAROUND:
  - gnt=0 and turn=1 for exactly TURN cycles.
  - On the edge where tcnt==TURN-1: turn=0.
  - If req != 0 at that edge, arbitrate as in IDLE in the same edge (new gnt appears immediately after the gap). Otherwise go to IDLE.
  - Requests arriving or dropping during turnaround are simply sampled at that final edge.
- Fairness:
  - ptr advances past the last owner even if that owner was cut off by MAX_HOLD and still requests.
  - The cut-off owner is therefore lowest priority next round.
  - With all N requesting, the service order is strictly 0,1,...,N-1,0,...
- Invariants (bench asserts every cycle):
  - gnt is one-hot or zero.
  - busy == |gnt.
  - turn and busy are never both high.
  - Between two different nonzero gnt values there are at least TURN zero cycles.
  - gnt[k]=1 only if req[k] was 1 at the previous edge.
- Counter widths: hold_cnt holds MAX_HOLD-1 and tcnt holds TURN-1 without overflow. The ptr wrap uses an explicit compare to N-1 (N need not be a power of 2).

Test Plan:
All cases use N=4, MAX_HOLD=4, TURN=1, and cycles are counted from the first edge with the stimulus applied.
1. Reset dominance: reset=1 for 2 cycles with req=4'b1111, then reset=0 -> gnt=0 and busy=0 during reset; gnt=4'b0001 and owner=0 at the first edge after release.
2. Short single request: req=4'b0010 for 2 cycles then 0 -> gnt=4'b0010 for 2 cycles, then turn=1 with gnt=0 for 1 cycle, then IDLE with all outputs 0.
3. Saturation rotation: req=4'b1111 held -> gnt sequence 0001×4, 0000×1, 0010×4, 0000×1, 0100×4, 0000×1, 1000×4, 0000×1, 0001×4; turn is high exactly on the 0000 cycles.
4. Pointer fairness: req=4'b0101; owner 0 releases after 1 cycle and req[0] re-asserts during turnaround -> next grant is 4'b0100, not 4'b0001.
5. Reset mid-grant: req=4'b1000 granted, reset pulsed 1 cycle on the second grant cycle -> gnt=0 with no turn cycle at the next edge; after release with req=4'b1001, gnt=4'b0001 (ptr back to 0).
6. Random stress: 10k cycles of random req with the invariant assertions above enabled -> zero violations, and every continuously requesting driver is granted within 4×(MAX_HOLD+TURN) cycles.
